systolic_mm_engine: RTL and testbench
=====================================

Name: systolic_mm_engine

Overview:
- Parametrised output-stationary ROWS x COLS systolic matrix-multiply engine: computes C = A x B with a runtime inner dimension K.
- Built-in input skewing, start/busy/done control and a valid/ready result drain.
- Next generation of the fixed 16x16 array. Sits between the operand fetch streamer (upstream) and the result writeback buffer (downstream).

Parameters:
- DATA_WIDTH, 8, operand width in bits.
- ROWS, 4, PE rows (rows of A and C), at least 1.
- COLS, 4, PE columns (columns of B and C), at least 1.
- ACC_WIDTH, 24, per-PE accumulator width, at least 2*DATA_WIDTH.
- K_WIDTH, 8, width of the k_len port.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  K_WIDTH  inner dimension K; latched on start.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last result row is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high in LOAD only.
- a_col  in  ROWS*DATA_WIDTH  column k of A; slice i is A[i][k].
- b_row  in  COLS*DATA_WIDTH  row k of B; slice j is B[k][j].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the result row.
- out_data  out  COLS*ACC_WIDTH  result row C[r]; slice j is C[r][j].
- out_row  out  $clog2(ROWS) (min 1)  index r of the row on out_data.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; accumulators, skew registers, PE pass registers and counters cleared. Reset mid-job abandons the job; no done pulse.
- State IDLE:
  - start=1 latches k_len and signed_mode, clears all accumulators and the beat counter.
  - Goes to LOAD, or to FLUSH when k_len=0.
  - start while busy is ignored.
- State LOAD:
  - in_ready=1. A beat is accepted when in_valid=1.
  - Cycles with in_valid=0 inject zero operands (bubbles), so results are unaffected.
  - After k_len accepted beats, go to FLUSH. in_ready drops in the cycle after the last beat.
- Skew: row i of A is delayed i cycles and column j of B is delayed j cycles, using shift registers. These shift zeros when no beat is accepted.
- Processing element (PE):
  - Registers its left and top operands and passes them right and down.
  - Accumulates the product of the registered operands.
  - A beat accepted at edge t updates PE(i,j) at edge t+i+j+2.
- Arithmetic: the product is 2*DATA_WIDTH wide, sign- or zero-extended per the latched signed_mode to ACC_WIDTH, then added modulo 2^ACC_WIDTH. Wrap is silent; no saturation.
- State FLUSH: lasts exactly ROWS+COLS cycles, counted by a counter, then goes to DRAIN.
- State DRAIN:
  - out_valid=1, out_row starts at 0, out_data = C[out_row].
  - Transfer when out_valid and out_ready. After a transfer, out_row increments.
  - After row ROWS-1 is transferred: done=1 for one cycle, state IDLE, out_valid=0.
  - While out_ready=0, out_data and out_row hold stable.
- Empty job (k_len=0): drain ROWS rows of all zeros.
- Accumulators hold their values after done until the next start.
- Job latency with no bubbles and no backpressure: K + ROWS + COLS + ROWS cycles from the first accepted beat to done.

Decomposition:
- Shared package sa_pkg: state enum (IDLE, LOAD, FLUSH, DRAIN), and a function returning the default ACC_WIDTH from DATA_WIDTH and K_WIDTH.
- One sub-module, sa_mac_pe: operand pass registers, signed/unsigned multiply, accumulator, synchronous clear input.
- Skew shift registers and the FSM stay in the top module.

Test Plan:
- Identity: ROWS=COLS=4, K=4, A=I, B[k][j]=4k+j+1, unsigned -> rows drained 0..3 equal B rows; done pulses once; busy falls the same cycle.
- Signed: A all 0xFF, B all 0xFF, K=3. signed_mode=1 -> every C=3. signed_mode=0 -> every C=3*65025=195075.
- Bubbles and backpressure: random in_valid gaps and out_ready toggling on random A/B, K=17 -> matches the golden model; out_data stable while stalled; out_row sequence 0,1,2,3.
- k_len=0: start -> no operand beat accepted; 4 all-zero rows; done pulse.
- Wrap: ACC_WIDTH=16, unsigned A=B=0xFF, K=2 -> C=(2*65025) mod 65536=64514.
- Reset mid-LOAD: assert rst after 5 beats -> outputs 0, state IDLE. A new job with K=4 identity gives correct results, proving the accumulators were cleared.

Source files
------------

// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic matrix-multiply engine:
//   - sa_state_t         : job controller states
//   - default_acc_width  : accumulator width that can hold a full-length dot
//                          product of 2^k_width terms without wrapping
// -----------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } sa_state_t;

    // Each product needs 2*data_width bits; summing up to 2^k_width of them
    // needs k_width more bits.
    function automatic int default_acc_width(input int data_width, input int k_width);
        return 2 * data_width + k_width;
    endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// -----------------------------------------------------------------------------
// sa_mac_pe
// One processing element of the output-stationary array. Registers the left
// and top operands, forwards them right/down, and accumulates the product of
// the registered operands every cycle (bubbles carry zeros, adding nothing).
// Ports:
//   clk, rst       clock, async active-high reset
//   clr            synchronous accumulator clear (job start)
//   signed_mode    1 = two's-complement operands, 0 = unsigned
//   a_in / a_out   left operand in, registered copy out to the right
//   b_in / b_out   top operand in, registered copy out downward
//   acc            accumulator value (modulo 2^ACC_WIDTH)
// -----------------------------------------------------------------------------
module sa_mac_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);

    // One extra bit on each operand lets a single signed multiplier serve
    // both modes; the product of two (DATA_WIDTH+1)-bit values fits PW bits.
    localparam int PW = 2 * DATA_WIDTH + 2;

    logic [DATA_WIDTH-1:0]      a_r;
    logic [DATA_WIDTH-1:0]      b_r;
    logic [ACC_WIDTH-1:0]       acc_r;
    logic signed [DATA_WIDTH:0] a_ext_s;
    logic signed [DATA_WIDTH:0] b_ext_s;
    logic signed [PW-1:0]       prod_s;

    // Mode-dependent extension and multiply of the registered operands.
    always_comb begin
        a_ext_s = $signed({signed_mode & a_r[DATA_WIDTH-1], a_r});
        b_ext_s = $signed({signed_mode & b_r[DATA_WIDTH-1], b_r});
        prod_s  = PW'(a_ext_s) * PW'(b_ext_s);
    end

    // Operand pass registers and wrapping accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else if (clr) begin
            a_r   <= a_in;
            b_r   <= b_in;
            acc_r <= '0;
        end else begin
            a_r   <= a_in;
            b_r   <= b_in;
            // Signed cast sign-extends (or truncates) the exact product.
            acc_r <= acc_r + ACC_WIDTH'(prod_s);
        end
    end

    assign a_out = a_r;
    assign b_out = b_r;
    assign acc   = acc_r;

endmodule

// File: rtl/systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// systolic_mm_engine
// Output-stationary ROWS x COLS systolic array computing C = A x B with a
// runtime inner dimension K. Operands arrive one k-slice per beat (column k of
// A, row k of B), are skewed into the array, and the finished C is drained one
// row per valid/ready transfer.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, k_len, signed_mode job launch (sampled in IDLE only)
//   busy, done               status; done pulses as the last row is taken
//   in_valid, in_ready       operand beat handshake (in_ready only in LOAD)
//   a_col, b_row             A[*][k] and B[k][*] for the current beat
//   out_valid, out_ready     result row handshake
//   out_data, out_row        result row C[out_row]
// -----------------------------------------------------------------------------
module systolic_mm_engine
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 8,
    parameter int ACC_WIDTH  = sa_pkg::default_acc_width(DATA_WIDTH, K_WIDTH),
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    input  logic                       signed_mode,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_col,
    input  logic [COLS*DATA_WIDTH-1:0] b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_WIDTH-1:0]  out_data,
    output logic [RW-1:0]              out_row
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int FW = $clog2(ROWS + COLS + 1);

    sa_state_t            state_r;
    sa_state_t            state_s;
    logic [K_WIDTH-1:0]   k_len_r;
    logic [K_WIDTH-1:0]   beat_cnt_r;
    logic                 signed_mode_r;
    logic [FW-1:0]        flush_cnt_r;
    logic [RW-1:0]        out_row_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 start_job_s;
    logic                 accept_s;
    logic                 xfer_s;
    logic [ROWS*DW-1:0]   a_beat_s;
    logic [COLS*DW-1:0]   b_beat_s;

    logic [DW-1:0] a_skew_s [ROWS];
    logic [DW-1:0] b_skew_s [COLS];
    logic [DW-1:0] a_pass_s [ROWS][COLS];
    logic [DW-1:0] b_pass_s [ROWS][COLS];
    logic [AW-1:0] acc_s    [ROWS][COLS];
    logic [ROWS*DW-1:0] a_edge_s;
    logic [COLS*DW-1:0] b_edge_s;
    logic               unused_edge_s;

    // Next-state and per-cycle strobes of the job controller.
    always_comb begin
        state_s     = state_r;
        start_job_s = 1'b0;
        accept_s    = 1'b0;
        xfer_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    start_job_s = 1'b1;
                    state_s     = (k_len == '0) ? FLUSH : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_s  = (beat_cnt_r == k_len_r - K_WIDTH'(1'b1)) ? FLUSH : LOAD;
                end else begin
                    state_s = LOAD;
                end
            end
            FLUSH: begin
                // ROWS+COLS cycles let the last beat reach PE(ROWS-1,COLS-1).
                if (flush_cnt_r == FW'(ROWS + COLS - 1)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FLUSH;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    xfer_s  = 1'b1;
                    state_s = (out_row_r == RW'(ROWS - 1)) ? IDLE : DRAIN;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered status/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            done_r      <= xfer_s && (state_s == IDLE);
            in_ready_r  <= (state_s == LOAD);
            out_valid_r <= (state_s == DRAIN);
        end
    end

    // Job parameters, beat/flush counters and drain row index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_r       <= '0;
            signed_mode_r <= 1'b0;
            beat_cnt_r    <= '0;
            flush_cnt_r   <= '0;
            out_row_r     <= '0;
        end else if (start_job_s) begin
            k_len_r       <= k_len;
            signed_mode_r <= signed_mode;
            beat_cnt_r    <= '0;
            flush_cnt_r   <= '0;
            out_row_r     <= '0;
        end else begin
            beat_cnt_r  <= accept_s ? beat_cnt_r + K_WIDTH'(1'b1) : beat_cnt_r;
            flush_cnt_r <= (state_r == FLUSH) ? flush_cnt_r + FW'(1'b1) : '0;
            if (xfer_s) begin
                out_row_r <= (out_row_r == RW'(ROWS - 1)) ? '0 : out_row_r + RW'(1'b1);
            end else begin
                out_row_r <= out_row_r;
            end
        end
    end

    // Unaccepted cycles feed zeros so bubbles leave the accumulators untouched.
    always_comb begin
        if (accept_s) begin
            a_beat_s = a_col;
            b_beat_s = b_row;
        end else begin
            a_beat_s = '0;
            b_beat_s = '0;
        end
    end

    // Row i of A enters through i+1 registers (input stage plus i delays).
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic [DW-1:0] sr_r [i+1];

        // A-side skew shift register for row i.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    sr_r[s] <= '0;
                end
            end else begin
                sr_r[0] <= a_beat_s[i*DW +: DW];
                for (int s = 1; s <= i; s++) begin
                    sr_r[s] <= sr_r[s-1];
                end
            end
        end

        assign a_skew_s[i] = sr_r[i];
    end

    // Column j of B enters through j+1 registers.
    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic [DW-1:0] sr_r [j+1];

        // B-side skew shift register for column j.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= j; s++) begin
                    sr_r[s] <= '0;
                end
            end else begin
                sr_r[0] <= b_beat_s[j*DW +: DW];
                for (int s = 1; s <= j; s++) begin
                    sr_r[s] <= sr_r[s-1];
                end
            end
        end

        assign b_skew_s[j] = sr_r[j];
    end

    // PE grid: operands flow right (A) and down (B).
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DW-1:0] a_left_s;
            logic [DW-1:0] b_top_s;

            if (j == 0) begin : g_a_src_skew
                assign a_left_s = a_skew_s[i];
            end else begin : g_a_src_pe
                assign a_left_s = a_pass_s[i][j-1];
            end

            if (i == 0) begin : g_b_src_skew
                assign b_top_s = b_skew_s[j];
            end else begin : g_b_src_pe
                assign b_top_s = b_pass_s[i-1][j];
            end

            sa_mac_pe #(
                .DATA_WIDTH (DW),
                .ACC_WIDTH  (AW)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clr         (start_job_s),
                .signed_mode (signed_mode_r),
                .a_in        (a_left_s),
                .b_in        (b_top_s),
                .a_out       (a_pass_s[i][j]),
                .b_out       (b_pass_s[i][j]),
                .acc         (acc_s[i][j])
            );
        end
    end

    // Operands leaving the right and bottom edges are dropped.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_edge
        assign a_edge_s[i*DW +: DW] = a_pass_s[i][COLS-1];
    end
    for (genvar j = 0; j < COLS; j++) begin : g_b_edge
        assign b_edge_s[j*DW +: DW] = b_pass_s[ROWS-1][j];
    end
    assign unused_edge_s = ^{a_edge_s, b_edge_s};

    // Result row mux; accumulators are static while draining, so data holds
    // stable under backpressure.
    always_comb begin
        out_data = '0;
        if (out_valid_r) begin
            for (int j = 0; j < COLS; j++) begin
                out_data[j*AW +: AW] = acc_s[out_row_r][j];
            end
        end else begin
            out_data = '0;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// tb_systolic_mm_engine
// Self-checking bench: operands are kept in plain arrays and C is computed as
// an ordinary sum of products modulo 2^ACC_WIDTH. A second instance with a
// 16-bit accumulator exercises wrap-around.
// -----------------------------------------------------------------------------
module tb_systolic_mm_engine;

    localparam int DW = 8, R = 4, C = 4, KW = 8, AW = 24, AW16 = 16, MAXK = 64;

    logic clk = 1'b0;
    logic rst, start, start16, signed_mode, in_valid, out_ready;
    logic [KW-1:0]   k_len;
    logic [R*DW-1:0] a_col;
    logic [C*DW-1:0] b_row;

    logic            busy, done, in_ready, out_valid;
    logic [C*AW-1:0] out_data;
    logic [1:0]      out_row;

    logic              busy16, done16, in_ready16, out_valid16;
    logic [C*AW16-1:0] out_data16;
    logic [1:0]        out_row16;

    int checks = 0;
    int errors = 0;
    int pos_cnt = 0;

    logic [7:0] a_m [R][MAXK];
    logic [7:0] b_m [MAXK][C];

    always #5 clk = ~clk;

    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    systolic_mm_engine #(
        .DATA_WIDTH(DW), .ROWS(R), .COLS(C), .K_WIDTH(KW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row)
    );

    systolic_mm_engine #(
        .DATA_WIDTH(DW), .ROWS(R), .COLS(C), .K_WIDTH(KW), .ACC_WIDTH(AW16)
    ) dut16 (
        .clk(clk), .rst(rst), .start(start16), .k_len(k_len), .signed_mode(signed_mode),
        .busy(busy16), .done(done16), .in_valid(in_valid), .in_ready(in_ready16),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_row(out_row16)
    );

    // Operand value under the chosen interpretation.
    function automatic longint sx(input logic [7:0] v, input bit sm);
        if (sm && v[7]) return longint'(v) - 64'sd256;
        else            return longint'(v);
    endfunction

    // C[r][j] = sum_k A[r][k]*B[k][j], reduced modulo 2^aw.
    function automatic longint exp_c(input int r, input int j, input int k, input bit sm, input int aw);
        longint s = 0;
        for (int kk = 0; kk < k; kk++) s += sx(a_m[r][kk], sm) * sx(b_m[kk][j], sm);
        return s & ((64'sd1 <<< aw) - 64'sd1);
    endfunction

    task automatic set_identity();
        for (int k = 0; k < R; k++) begin
            for (int i = 0; i < R; i++) a_m[i][k] = (i == k) ? 8'd1 : 8'd0;
            for (int j = 0; j < C; j++) b_m[k][j] = 8'(4 * k + j + 1);
        end
    endtask

    task automatic set_all(input int k, input logic [7:0] v);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) a_m[i][kk] = v;
            for (int j = 0; j < C; j++) b_m[kk][j] = v;
        end
    endtask

    task automatic set_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) a_m[i][kk] = 8'($urandom);
            for (int j = 0; j < C; j++) b_m[kk][j] = 8'($urandom);
        end
    endtask

    task automatic drive_beat(input int idx);
        for (int i = 0; i < R; i++) a_col[i*DW +: DW] = a_m[i][idx];
        for (int j = 0; j < C; j++) b_row[j*DW +: DW] = b_m[idx][j];
    endtask

    // One full job on the main instance, checked against the array model.
    task automatic run_job(input string name, input int k, input bit sm, input int bub,
                           input int bp, input bit chk_lat, input bit poke);
        int idx, guard, row, first_edge, lat;
        bit v, rdy, prev_stall;
        logic [C*AW-1:0] prev_data;
        logic [1:0]      prev_row;
        @(negedge clk);
        start = 1'b1; k_len = k[KW-1:0]; signed_mode = sm; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; k_len = 8'($urandom); signed_mode = 1'($urandom);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_on: got %b want 1", name, busy); end
        first_edge = 0; idx = 0; guard = 0; rdy = 1'b0;
        if (k == 0) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s empty_ready: got %b want 0", name, in_ready); end
            in_valid = 1'b1; a_col = $urandom; b_row = $urandom;
        end
        while (idx < k && guard < 4000) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s load_ready: got %b want 1", name, in_ready); end
            v = ($urandom_range(99) >= bub);
            if (poke) begin start = 1'($urandom); k_len = 8'($urandom); end
            if (v) begin
                drive_beat(idx);
                if (idx == 0) first_edge = pos_cnt + 1;
                idx++;
            end else begin
                a_col = $urandom; b_row = $urandom;
            end
            in_valid = v;
            @(negedge clk); guard++;
        end
        start = 1'b0;
        if (idx < k) begin checks++; errors++; $display("FAIL %s load_timeout: got %0d beats want %0d", name, idx, k); end
        if (k > 0) begin
            in_valid = 1'b0;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s ready_drop: got %b want 0", name, in_ready); end
        end
        row = 0; guard = 0; prev_stall = 1'b0; prev_data = '0; prev_row = '0;
        while (row < R && guard < 4000) begin
            if (out_valid === 1'b1) begin
                if (prev_stall) begin
                    checks++;
                    if (out_data !== prev_data || out_row !== prev_row) begin
                        errors++; $display("FAIL %s stall_hold: got row %0d data %h want row %0d data %h", name, out_row, out_data, prev_row, prev_data);
                    end
                end
                checks++; if (out_row !== 2'(row)) begin errors++; $display("FAIL %s out_row: got %0d want %0d", name, out_row, row); end
                for (int j = 0; j < C; j++) begin
                    longint e = exp_c(row, j, k, sm, AW);
                    checks++;
                    if (longint'(out_data[j*AW +: AW]) !== e) begin
                        errors++; $display("FAIL %s C[%0d][%0d]: got %0d want %0d", name, row, j, out_data[j*AW +: AW], e);
                    end
                end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s early_done: got %b want 0", name, done); end
                rdy = ($urandom_range(99) >= bp);
                prev_stall = !rdy; prev_data = out_data; prev_row = out_row;
                if (rdy) row++;
            end else begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_hold: got %b want 1", name, busy); end
                rdy = 1'($urandom); prev_stall = 1'b0;
            end
            out_ready = rdy;
            @(negedge clk); guard++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        if (row < R) begin checks++; errors++; $display("FAIL %s drain_timeout: got %0d rows want %0d", name, row, R); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse: got %b want 1", name, done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_off: got %b want 0", name, busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s valid_off: got %b want 0", name, out_valid); end
        if (chk_lat) begin
            lat = pos_cnt - first_edge + 1;
            checks++; if (lat != k + 2 * R + C) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, k + 2 * R + C); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", name, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start16 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        k_len = '0; signed_mode = 1'b0; a_col = '0; b_row = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_row !== 2'd0)   begin errors++; $display("FAIL reset_out_row: got %0d want 0", out_row); end
        checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (busy16 !== 1'b0)    begin errors++; $display("FAIL reset_busy16: got %b want 0", busy16); end
    endtask

    task automatic test_identity();
        set_identity();
        run_job("identity", 4, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_signed();
        set_all(3, 8'hFF);
        run_job("signed_ff", 3, 1'b1, 0, 0, 1'b1, 1'b0);
        run_job("unsigned_ff", 3, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_bubbles_backpressure();
        set_random(17);
        run_job("rand_signed", 17, 1'b1, 40, 40, 1'b0, 1'b0);
        set_random(17);
        run_job("rand_unsigned", 17, 1'b0, 40, 40, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        run_job("empty", 0, 1'b0, 0, 30, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        int guard;
        set_all(2, 8'hFF);
        @(negedge clk);
        start16 = 1'b1; k_len = 8'd2; signed_mode = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        for (int b = 0; b < 2; b++) begin
            checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b want 1", in_ready16); end
            drive_beat(b); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1; guard = 0;
        while (out_valid16 !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        for (int r = 0; r < R; r++) begin
            checks++; if (out_row16 !== 2'(r)) begin errors++; $display("FAIL wrap_row: got %0d want %0d", out_row16, r); end
            for (int j = 0; j < C; j++) begin
                longint e = exp_c(r, j, 2, 1'b0, AW16);
                checks++;
                if (longint'(out_data16[j*AW16 +: AW16]) !== e) begin
                    errors++; $display("FAIL wrap C[%0d][%0d]: got %0d want %0d", r, j, out_data16[j*AW16 +: AW16], e);
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL wrap_busy: got %b want 0", busy16); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        k1 = $urandom_range(20, 1);
        set_random(k1);
        run_job("b2b_first", k1, 1'b1, 20, 0, 1'b0, 1'b1);
        k2 = $urandom_range(20, 1);
        set_random(k2);
        run_job("b2b_second", k2, 1'b0, 20, 30, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        set_random(10);
        @(negedge clk);
        start = 1'b1; k_len = 8'd10; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            drive_beat(b); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (out_data !== '0)    begin errors++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", done); end
        set_identity();
        run_job("after_reset_identity", 4, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_bubbles_backpressure();
        test_empty();
        test_wrap();
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
